// File: rtl/fetch_phase.sv
// Fetch-side instruction queue: buffers {inst, pc} words arriving from instruction
// memory, hides the read-latency warm-up and applies back-pressure via PC rewind.
module fetch_phase #(
  parameter int LOAD_LATENCY = 1,
  parameter int FQ_DEPTH     = 4,
  parameter int ADDR_W       = 32,
  parameter int INST_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_to_fet,
  input  logic [INST_W-1:0] inst_rdata,
  input  logic              flush,
  output logic              stall_pc,
  output logic              fd_valid,
  output logic [INST_W-1:0] fd_inst,
  output logic [ADDR_W-1:0] fd_pc,
  input  logic              de_ready
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WU_W  = $clog2(LOAD_LATENCY + 1);

  logic [INST_W-1:0] mem_inst [FQ_DEPTH];
  logic [ADDR_W-1:0] mem_pc   [FQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [WU_W-1:0]   wu;

  logic arrival_ok;
  logic full;
  logic pop;
  logic push;

  always_comb begin
    arrival_ok = (wu == '0) & ~flush;
    full       = (count == CNT_W'(FQ_DEPTH));
    fd_valid   = (count != '0) & ~flush;
    pop        = fd_valid & de_ready;
    // At full, a same-cycle pop frees the slot the arrival will land in.
    stall_pc   = arrival_ok & full & ~pop;
    push       = arrival_ok & ~stall_pc;
    fd_inst    = mem_inst[rd_ptr];
    fd_pc      = mem_pc[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wu     <= WU_W'(LOAD_LATENCY);
      for (int i = 0; i < FQ_DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      if (wu != '0)
        wu <= wu - WU_W'(1);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem_inst[wr_ptr] <= inst_rdata;
          mem_pc[wr_ptr]   <= pc_to_fet;
          wr_ptr           <= wr_ptr + PTR_W'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_phase.sv
// Bench for fetch_phase: directed scenarios followed by random traffic, all checked
// against a queue-based model of the fetch buffer.
module tb_fetch_phase;

  localparam int LL = 1;
  localparam int D  = 4;
  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          de_ready;
  logic [AW-1:0] pc_to_fet;
  logic [IW-1:0] inst_rdata;
  logic          stall_pc;
  logic          fd_valid;
  logic [IW-1:0] fd_inst;
  logic [AW-1:0] fd_pc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_phase #(.LOAD_LATENCY(LL), .FQ_DEPTH(D), .ADDR_W(AW), .INST_W(IW)) dut (
    .clk(clk), .rst(rst), .pc_to_fet(pc_to_fet), .inst_rdata(inst_rdata),
    .flush(flush), .stall_pc(stall_pc), .fd_valid(fd_valid), .fd_inst(fd_inst),
    .fd_pc(fd_pc), .de_ready(de_ready)
  );

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t q[$];
  int   wu_m = LL;
  logic exp_valid = 1'b0;
  logic exp_pop   = 1'b0;
  logic exp_stall = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit dr,
                       input logic [IW-1:0] inst, input logic [AW-1:0] pc);
    rst        = r;
    flush      = f;
    de_ready   = dr;
    inst_rdata = inst;
    pc_to_fet  = pc;
  endtask

  // Mid-cycle: compare combinational outputs against the model's view of the queue.
  task automatic cyc();
    @(negedge clk);
    exp_valid = (q.size() != 0) && !flush;
    exp_pop   = exp_valid && de_ready;
    exp_stall = (wu_m == 0) && !flush && (q.size() == D) && !exp_pop;
    check("fd_valid", 64'(fd_valid), 64'(exp_valid));
    check("stall_pc", 64'(stall_pc), 64'(exp_stall));
    if (exp_valid) begin
      check("head_inst", 64'(fd_inst), 64'(q[0].inst));
      check("head_pc", 64'(fd_pc), 64'(q[0].pc));
    end
  endtask

  task automatic tick();
    bit accept;
    accept = (wu_m == 0) && !flush && !exp_stall;
    @(posedge clk);
    if (rst) begin
      q.delete();
      wu_m = LL;
    end else begin
      if (wu_m > 0) wu_m--;
      if (flush) q.delete();
      else begin
        if (exp_pop) void'(q.pop_front());
        if (accept) q.push_back({inst_rdata, pc_to_fet});
      end
    end
    #1;
  endtask

  initial begin
    // Reset
    drive(1, 0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    q.delete();
    wu_m = LL;
    drive(1, 0, 1, 32'hDEAD, 32'hBEEF);
    cyc();
    check("rst_valid", 64'(fd_valid), 64'd0);
    check("rst_inst", 64'(fd_inst), 64'd0);
    check("rst_pc", 64'(fd_pc), 64'd0);
    check("rst_stall", 64'(stall_pc), 64'd0);
    tick();

    // Warm-up: first arrival after reset is dropped
    drive(0, 0, 0, 32'hA0, 32'h10); cyc(); check("wu_stall", 64'(stall_pc), 64'd0); tick();
    drive(0, 0, 0, 32'hA1, 32'h11); cyc(); check("wu_empty", 64'(fd_valid), 64'd0); tick();
    drive(0, 0, 0, 32'hEE, 32'h20); cyc();
    check("wu_valid", 64'(fd_valid), 64'd1);
    check("wu_inst", 64'(fd_inst), 64'hA1);
    check("wu_pc", 64'(fd_pc), 64'h11);
    tick();

    // Fill to full, fifth arrival stalls
    drive(0, 1, 0, 32'h0, 32'h0); cyc(); tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 32'hB0 + k, 32'h30 + k); cyc(); tick();
    end
    drive(0, 0, 0, 32'hB4, 32'h34); cyc();
    check("fill_stall", 64'(stall_pc), 64'd1);
    check("fill_head", 64'(fd_inst), 64'hB0);
    tick();

    // Full with pop: no stall, arrival stored behind B3
    drive(0, 0, 1, 32'hB4, 32'h34); cyc();
    check("fullpop_stall", 64'(stall_pc), 64'd0);
    check("fullpop_head", 64'(fd_inst), 64'hB0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 32'hD0 + k, 32'h40 + k); cyc();
      check("fullpop_seq", 64'(fd_inst), 64'(32'hB1 + k));
      tick();
    end

    // Wrap: 12 arrivals with toggling de_ready
    drive(0, 1, 0, 32'h0, 32'h0); cyc(); tick();
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 1'(k % 2 == 0), 32'hE0 + k, 32'h60 + k); cyc(); tick();
    end
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 32'hE80 + k, 32'h80 + k); cyc(); tick();
    end

    // Flush with 3 entries queued
    drive(0, 1, 0, 32'h0, 32'h0); cyc(); tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 32'hF0 + k, 32'h70 + k); cyc(); tick();
    end
    drive(0, 1, 1, 32'hC0, 32'h50); cyc();
    check("flush_valid", 64'(fd_valid), 64'd0);
    check("flush_stall", 64'(stall_pc), 64'd0);
    tick();
    drive(0, 0, 0, 32'hC1, 32'h51); cyc();
    check("flush_empty", 64'(fd_valid), 64'd0);
    tick();
    drive(0, 0, 0, 32'hC2, 32'h52); cyc();
    check("flush_next_valid", 64'(fd_valid), 64'd1);
    check("flush_next_inst", 64'(fd_inst), 64'hC1);
    check("flush_next_pc", 64'(fd_pc), 64'h51);
    tick();

    // Reset mid-stream with concurrent push/pop
    drive(0, 1, 0, 32'h0, 32'h0); cyc(); tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 32'h90 + k, 32'h90 + k); cyc(); tick();
    end
    drive(1, 0, 1, 32'h93, 32'h93); cyc(); tick();
    drive(0, 0, 1, 32'h94, 32'h94); cyc();
    check("midrst_valid", 64'(fd_valid), 64'd0);
    check("midrst_inst", 64'(fd_inst), 64'd0);
    check("midrst_pc", 64'(fd_pc), 64'd0);
    check("midrst_stall", 64'(stall_pc), 64'd0);
    tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(99) == 0), 1'($urandom_range(15) == 0),
            1'($urandom_range(1)), IW'($urandom), AW'($urandom));
      cyc();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
